// File: rtl/switch_alloc0.sv
// switch_alloc0: five-port wormhole switch allocator for router0 of the 4x4 mesh.
// Each output arbitrates round-robin among eligible header flits. It then stays
// locked to the winning input until that packet's tail flit has been transferred.
// Port order everywhere: 0=L, 1=E, 2=W, 3=S, 4=N.
// Optional build macro: SWITCH_ALLOC0_ERR_EN adds a sticky protocol error output 'err'.

module switch_alloc0 #(
    parameter int NPORT = 5,
    parameter int SEL_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORT-1:0]         in_valid,
    input  logic [2*NPORT-1:0]       in_type,
    input  logic [NPORT*NPORT-1:0]   in_req,
    input  logic [NPORT-1:0]         out_ready,
    output logic [NPORT-1:0]         in_pop,
    output logic [NPORT-1:0]         out_valid,
    output logic [NPORT*SEL_W-1:0]   out_sel,
    output logic [NPORT-1:0]         out_busy
`ifdef SWITCH_ALLOC0_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int NSLOT = 1 << SEL_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Per-output lock state, owning input and round-robin pointer.
    state_e           state_q [NPORT];
    state_e           state_d [NPORT];
    logic [SEL_W-1:0] owner_q [NPORT];
    logic [SEL_W-1:0] owner_d [NPORT];
    logic [SEL_W-1:0] ptr_q   [NPORT];
    logic [SEL_W-1:0] ptr_d   [NPORT];

    // Per-input views padded to every owner code, so an owner register indexes them directly.
    logic [NSLOT-1:0] valid_x;
    logic [NSLOT-1:0] last_x;
    logic [NSLOT-1:0] cand_x [NPORT];
    logic [NPORT-1:0] xfer;

    // Decode each input's head flit and build the candidate set of every output.
    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        valid_x = '0;
        last_x  = '0;
        for (int o = 0; o < NPORT; o++) begin
            cand_x[o] = '0;
        end
        for (int i = 0; i < NPORT; i++) begin
            valid_x[i] = in_valid[i];
            // Type bit 0 marks the end of a packet (tail or single-flit).
            last_x[i]  = in_type[2*i];
            for (int o = 0; o < NPORT; o++) begin
                // Type bit 1 marks a header (header or single-flit); the request must be exactly one-hot.
                cand_x[o][i] = in_valid[i] & in_type[2*i+1]
                             & $onehot(in_req[NPORT*i +: NPORT])
                             & in_req[NPORT*i+o];
            end
        end
    end

    // Crossbar drive from registered state, in_valid and out_ready only.
    always_comb begin
        in_pop    = '0;
        out_valid = '0;
        out_sel   = '0;
        out_busy  = '0;
        xfer      = '0;
        for (int o = 0; o < NPORT; o++) begin
            out_busy[o]               = (state_q[o] == ST_LOCKED);
            out_sel[SEL_W*o +: SEL_W] = owner_q[o];
            out_valid[o]              = out_busy[o] & valid_x[owner_q[o]];
            xfer[o]                   = out_valid[o] & out_ready[o];
            for (int i = 0; i < NPORT; i++) begin
                if (owner_q[o] == SEL_W'(i)) begin
                    in_pop[i] = in_pop[i] | xfer[o];
                end
            end
        end
    end

    // Next state per output: round-robin grant while idle, release after a popped tail.
    always_comb begin
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] idx;
        logic             found;
        sum   = '0;
        idx   = '0;
        found = 1'b0;
        for (int o = 0; o < NPORT; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            found      = 1'b0;
            if (state_q[o] == ST_LOCKED) begin
                if (xfer[o] && last_x[owner_q[o]]) begin
                    state_d[o] = ST_IDLE;
                end
            end else begin
                // Scan ptr+1, ptr+2, ... modulo NPORT; the first candidate wins.
                for (int k = 1; k <= NPORT; k++) begin
                    sum = {1'b0, ptr_q[o]} + (SEL_W+1)'(k);
                    if (sum >= (SEL_W+1)'(NPORT)) begin
                        sum = sum - (SEL_W+1)'(NPORT);
                    end
                    idx = sum[SEL_W-1:0];
                    if (!found && cand_x[o][idx]) begin
                        found      = 1'b1;
                        state_d[o] = ST_LOCKED;
                        owner_d[o] = idx;
                        ptr_d[o]   = idx;
                    end
                end
            end
        end
    end

    // State registers; reset drops every lock and gives input 0 first priority.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        for (int o = 0; o < NPORT; o++) begin
            if (rst) begin
                state_q[o] <= ST_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= SEL_W'(NPORT-1);
            end else begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

`ifdef SWITCH_ALLOC0_ERR_EN
    logic [NPORT-1:0] owned;
    logic [NPORT-1:0] bad_flit;
    logic             err_q;
    logic             err_d;

    // Flag an unowned input holding a non-request header or a mid-packet flit.
    always_comb begin
        owned    = '0;
        bad_flit = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if ((state_q[o] == ST_LOCKED) && (owner_q[o] == SEL_W'(i))) begin
                    owned[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            bad_flit[i] = in_valid[i] & ~owned[i]
                        & (~in_type[2*i+1] | ~$onehot(in_req[NPORT*i +: NPORT]));
        end
        err_d = err_q | (|bad_flit);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_switch_alloc0.sv
// Testbench for switch_alloc0: a packet-level model of the allocator (lock, owner,
// round-robin pointer per output) is compared with the DUT on every cycle, and
// directed scenarios pin the model with hand-computed expectations.

module tb_switch_alloc0;

    localparam int NP = 5;

    typedef struct {
        logic [1:0] typ;
        logic [4:0] req;
        int         pkt;
    } flit_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  in_valid = '0;
    logic [9:0]  in_type = '0;
    logic [24:0] in_req = '0;
    logic [4:0]  out_ready = '0;
    logic [4:0]  in_pop;
    logic [4:0]  out_valid;
    logic [14:0] out_sel;
    logic [4:0]  out_busy;
`ifdef SWITCH_ALLOC0_ERR_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    switch_alloc0 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_type  (in_type),
        .in_req   (in_req),
        .out_ready(out_ready),
        .in_pop   (in_pop),
        .out_valid(out_valid),
        .out_sel  (out_sel),
        .out_busy (out_busy)
`ifdef SWITCH_ALLOC0_ERR_EN
        ,
        .err      (err)
`endif
    );

    int         total = 0;
    int         bad = 0;
    bit         chk_en = 1'b0;
    logic [4:0] ready_v = '1;
    flit_t      fq [NP][$];

    // Model state
    bit m_lock [NP];
    int m_own  [NP];
    int m_ptr  [NP];
    bit m_err;

    // Observations of the DUT gathered by the compare process
    int         pop_cnt  [NP];
    int         busy_cnt [NP];
    int         grant_log [NP][$];
    logic [4:0] prev_busy = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the model's lock table and the pins currently driven.
    function automatic void model_out(output logic [4:0] pop, output logic [4:0] val,
                                      output logic [14:0] sel, output logic [4:0] busy);
        pop  = '0;
        val  = '0;
        sel  = '0;
        busy = '0;
        for (int o = 0; o < NP; o++) begin
            busy[o]       = m_lock[o];
            sel[3*o +: 3] = 3'(m_own[o]);
            if (m_lock[o] && in_valid[m_own[o]]) begin
                val[o] = 1'b1;
                if (out_ready[o]) pop[m_own[o]] = 1'b1;
            end
        end
    endfunction

    // Advance the model over one clock edge and retire the flits it transferred.
    task automatic model_update();
        logic [4:0]  pop, val, busy;
        logic [14:0] sel;
        bit          nl [NP];
        int          no [NP];
        int          np [NP];
        bit          found;
        bit          owned;
        int          c;
        if (rst) begin
            for (int o = 0; o < NP; o++) begin
                m_lock[o] = 1'b0;
                m_own[o]  = 0;
                m_ptr[o]  = 4;
            end
            m_err = 1'b0;
            return;
        end
        model_out(pop, val, sel, busy);
        for (int i = 0; i < NP; i++) begin
            owned = 1'b0;
            for (int o = 0; o < NP; o++) if (m_lock[o] && m_own[o] == i) owned = 1'b1;
            if (in_valid[i] && !owned &&
                (!in_type[2*i+1] || $countones(in_req[5*i +: 5]) != 1)) m_err = 1'b1;
        end
        for (int o = 0; o < NP; o++) begin
            nl[o] = m_lock[o];
            no[o] = m_own[o];
            np[o] = m_ptr[o];
            if (m_lock[o]) begin
                if (val[o] && out_ready[o] && in_type[2*m_own[o]]) nl[o] = 1'b0;
            end else begin
                found = 1'b0;
                for (int k = 1; k <= NP; k++) begin
                    c = (m_ptr[o] + k) % NP;
                    if (!found && in_valid[c] && in_type[2*c+1] &&
                        $countones(in_req[5*c +: 5]) == 1 && in_req[5*c+o]) begin
                        found = 1'b1;
                        nl[o] = 1'b1;
                        no[o] = c;
                        np[o] = c;
                    end
                end
            end
        end
        for (int o = 0; o < NP; o++) begin
            if (m_lock[o] && val[o] && out_ready[o] && fq[m_own[o]].size() > 0)
                void'(fq[m_own[o]].pop_front());
        end
        for (int o = 0; o < NP; o++) begin
            m_lock[o] = nl[o];
            m_own[o]  = no[o];
            m_ptr[o]  = np[o];
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            if (fq[i].size() > 0) begin
                in_valid[i]       = 1'b1;
                in_type[2*i +: 2] = fq[i][0].typ;
                in_req[5*i +: 5]  = fq[i][0].req;
            end else begin
                in_valid[i]       = 1'b0;
                in_type[2*i +: 2] = 2'b00;
                in_req[5*i +: 5]  = 5'b00000;
            end
        end
        out_ready = ready_v;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        drive();
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push_pkt(input int port, input int outp, input int len, input int pkt);
        flit_t f;
        f.req = 5'b00001 << outp;
        f.pkt = pkt;
        for (int n = 0; n < len; n++) begin
            if (len == 1)           f.typ = 2'b11;
            else if (n == 0)        f.typ = 2'b10;
            else if (n == len - 1)  f.typ = 2'b01;
            else                    f.typ = 2'b00;
            fq[port].push_back(f);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NP; i++) if (fq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_obs();
        for (int i = 0; i < NP; i++) begin
            pop_cnt[i]  = 0;
            busy_cnt[i] = 0;
            grant_log[i].delete();
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!all_empty() && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(all_empty()), 32'd1);
        tick();
        tick();
    endtask

    // Compare process: DUT against the model on every cycle once reset has been applied.
    always @(negedge clk) begin : cmp
        logic [4:0]  ep, ev, eb;
        logic [14:0] es;
        if (chk_en) begin
            model_out(ep, ev, es, eb);
            check("in_pop", 32'(in_pop), 32'(ep));
            check("out_valid", 32'(out_valid), 32'(ev));
            check("out_sel", 32'(out_sel), 32'(es));
            check("out_busy", 32'(out_busy), 32'(eb));
`ifdef SWITCH_ALLOC0_ERR_EN
            check("err", 32'(err), 32'(m_err));
`endif
            for (int i = 0; i < NP; i++) begin
                pop_cnt[i]  += int'(in_pop[i]);
                busy_cnt[i] += int'(out_busy[i]);
                if (out_busy[i] && !prev_busy[i]) grant_log[i].push_back(int'(out_sel[3*i +: 3]));
            end
            prev_busy = out_busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        rst = 1'b1;
        drive();
        tick();
        tick();
        chk_en = 1'b1;
        neg();
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_pop", 32'(in_pop), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sel", 32'(out_sel), 32'd0);
        tick();
        rst = 1'b0;

        // Single-flit packet L -> E
        clear_obs();
        push_pkt(0, 1, 1, 10);
        drive();
        neg();
        check("t1_c0_busy", 32'(out_busy), 32'd0);
        check("t1_c0_pop", 32'(in_pop), 32'd0);
        tick();
        neg();
        check("t1_c1_busy", 32'(out_busy), 32'b00010);
        check("t1_c1_sel", 32'(out_sel[5:3]), 32'd0);
        check("t1_c1_pop", 32'(in_pop), 32'b00001);
        check("t1_c1_valid", 32'(out_valid), 32'b00010);
        tick();
        neg();
        check("t1_c2_busy", 32'(out_busy), 32'd0);
        check("t1_c2_pop", 32'(in_pop), 32'd0);
        tick();

        // Inputs 1,2,3 each send 3 flits to N at once
        clear_obs();
        push_pkt(1, 4, 3, 21);
        push_pkt(2, 4, 3, 22);
        push_pkt(3, 4, 3, 23);
        drive();
        drain("t2_drain", 40);
        check("t2_ngrant", 32'(grant_log[4].size()), 32'd3);
        if (grant_log[4].size() == 3) begin
            check("t2_grant0", 32'(grant_log[4][0]), 32'd1);
            check("t2_grant1", 32'(grant_log[4][1]), 32'd2);
            check("t2_grant2", 32'(grant_log[4][2]), 32'd3);
        end
        check("t2_busy_cycles", 32'(busy_cnt[4]), 32'd9);
        check("t2_pops_in1", 32'(pop_cnt[1]), 32'd3);
        check("t2_pops_in3", 32'(pop_cnt[3]), 32'd3);

        // S -> L, 4 flits, output stalled 4 cycles after the header
        clear_obs();
        push_pkt(3, 0, 4, 30);
        drive();
        neg();
        tick();
        neg();
        check("t3_hdr_pop", 32'(in_pop), 32'b01000);
        tick();
        ready_v[0] = 1'b0;
        drive();
        for (int s = 0; s < 4; s++) begin
            neg();
            check("t3_stall_pop", 32'(in_pop[3]), 32'd0);
            check("t3_stall_busy", 32'(out_busy[0]), 32'd1);
            check("t3_stall_valid", 32'(out_valid[0]), 32'd1);
            tick();
        end
        ready_v[0] = 1'b1;
        drive();
        drain("t3_drain", 20);
        check("t3_pops_in3", 32'(pop_cnt[3]), 32'd4);
        check("t3_busy_cycles", 32'(busy_cnt[0]), 32'd8);

        // L -> E and E -> W in the same cycle
        clear_obs();
        push_pkt(0, 1, 2, 40);
        push_pkt(1, 2, 3, 41);
        drive();
        neg();
        tick();
        neg();
        check("t4_busy", 32'(out_busy), 32'b00110);
        check("t4_pop", 32'(in_pop), 32'b00011);
        check("t4_sel_e", 32'(out_sel[5:3]), 32'd0);
        check("t4_sel_w", 32'(out_sel[8:6]), 32'd1);
        tick();
        neg();
        check("t4_c2_pop", 32'(in_pop), 32'b00011);
        drain("t4_drain", 20);
        check("t4_pops_in0", 32'(pop_cnt[0]), 32'd2);
        check("t4_pops_in1", 32'(pop_cnt[1]), 32'd3);

        // Multi-hot header on W input is never a request
        begin
            flit_t f;
            f.typ = 2'b10;
            f.req = 5'b00110;
            f.pkt = 50;
            fq[2].push_back(f);
        end
        drive();
        neg();
        check("t5_c0_busy", 32'(out_busy), 32'd0);
`ifdef SWITCH_ALLOC0_ERR_EN
        check("t5_c0_err", 32'(err), 32'd0);
`endif
        for (int s = 0; s < 3; s++) begin
            tick();
            neg();
            check("t5_no_pop", 32'(in_pop[2]), 32'd0);
            check("t5_no_busy", 32'(out_busy), 32'd0);
`ifdef SWITCH_ALLOC0_ERR_EN
            check("t5_err", 32'(err), 32'd1);
`endif
        end

        // N -> W 5 flits, reset asserted mid-packet
        tick();
        clear_obs();
        push_pkt(4, 2, 5, 60);
        drive();
        neg();
        tick();
        neg();
        check("t6_lock", 32'(out_busy), 32'b00100);
        check("t6_hdr_pop", 32'(in_pop), 32'b10000);
        tick();
        neg();
        tick();
        rst = 1'b1;
        neg();
        check("t6_mid_busy", 32'(out_busy), 32'b00100);
        tick();
        neg();
        check("t6_rst_busy", 32'(out_busy), 32'd0);
        check("t6_rst_pop", 32'(in_pop), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_sel", 32'(out_sel), 32'd0);
`ifdef SWITCH_ALLOC0_ERR_EN
        check("t6_rst_err", 32'(err), 32'd0);
`endif
        tick();
        for (int i = 0; i < NP; i++) fq[i].delete();
        rst = 1'b0;
        drive();
        clear_obs();
        push_pkt(3, 2, 1, 70);
        drive();
        neg();
        check("t6_new_c0_busy", 32'(out_busy), 32'd0);
        tick();
        neg();
        check("t6_new_busy", 32'(out_busy), 32'b00100);
        check("t6_new_sel", 32'(out_sel[8:6]), 32'd3);
        check("t6_new_pop", 32'(in_pop), 32'b01000);
        drain("t6_drain", 10);
        neg();
        check("t6_idle_busy", 32'(out_busy), 32'd0);
`ifdef SWITCH_ALLOC0_ERR_EN
        check("t6_end_err", 32'(err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
